// File: rtl/lsu_access_sequencer.sv
// Load/store sequencer: turns one core access into one or two aligned word beats
// on a req/gnt/rvalid data bus (one outstanding beat) and returns extended load data.
module lsu_access_sequencer #(
  parameter int XLEN               = 32,
  parameter bit SUPPORT_MISALIGNED = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            lsu_valid_i,
  output logic            lsu_ready_o,
  input  logic [XLEN-1:0] lsu_addr_i,
  input  logic            lsu_we_i,
  input  logic [1:0]      lsu_size_i,
  input  logic            lsu_unsigned_i,
  input  logic [XLEN-1:0] lsu_wdata_i,
  output logic            lsu_done_o,
  output logic            lsu_err_o,
  output logic [XLEN-1:0] lsu_rdata_o,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic            mem_we_o,
  output logic [3:0]      mem_be_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic [2:0]      dbg_state_o
);

  // Handshakes: a core request transfers on a rising edge with lsu_valid_i && lsu_ready_o.
  // A bus beat holds mem_req_o and its fields stable until the edge where mem_gnt_i is high;
  // a granted read returns exactly one mem_rvalid_i, taken only in the matching WAIT state.

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ1  = 3'd1,
    WAIT1 = 3'd2,
    REQ2  = 3'd3,
    WAIT2 = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0] addr_q;
  logic            we_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] rdata1_q;
  logic [23:0]     rdata2_q;
  logic [XLEN-1:0] rdata_q;

  logic            accept;
  logic [1:0]      in_off;
  logic            in_misaligned;
  logic            in_illegal;

  logic [1:0]      off;
  logic [3:0]      lane_m;
  logic [2:0]      nbytes;
  logic            spans;
  logic [7:0]      mask64;
  logic [2*XLEN-1:0] wd64;
  logic [XLEN-1:0] word_addr;

  logic [XLEN-1:0] rdata1_n;
  logic [23:0]     rdata2_n;
  logic [XLEN-1:0] merged;
  logic [XLEN-1:0] extended;

  // Request decode on the incoming (not yet registered) fields
  always_comb begin
    in_off        = lsu_addr_i[1:0];
    in_misaligned = ((lsu_size_i == 2'b01) && in_off[0]) ||
                    ((lsu_size_i == 2'b10) && (in_off != 2'b00));
    in_illegal    = (lsu_size_i == 2'b11) || (!SUPPORT_MISALIGNED && in_misaligned);
    accept        = lsu_valid_i && lsu_ready_o;
  end

  // Lane maps for the registered access
  always_comb begin
    off = addr_q[1:0];
    case (size_q)
      2'b00:   begin lane_m = 4'b0001; nbytes = 3'd1; end
      2'b01:   begin lane_m = 4'b0011; nbytes = 3'd2; end
      default: begin lane_m = 4'b1111; nbytes = 3'd4; end
    endcase
    spans     = ({1'b0, off} + nbytes) > 3'd4;
    mask64    = {4'b0000, lane_m} << off;
    wd64      = {{XLEN{1'b0}}, wdata_q} << {off, 3'b000};
    word_addr = {addr_q[XLEN-1:2], 2'b00};
  end

  // Load merge uses the word arriving this cycle so the result can be registered into DONE
  always_comb begin
    rdata1_n = rdata1_q;
    rdata2_n = rdata2_q;
    if (state_q == WAIT1 && mem_rvalid_i) rdata1_n = mem_rdata_i;
    if (state_q == WAIT2 && mem_rvalid_i) rdata2_n = mem_rdata_i[23:0];
    case (off)
      2'd0:    merged = rdata1_n;
      2'd1:    merged = {rdata2_n[7:0],  rdata1_n[31:8]};
      2'd2:    merged = {rdata2_n[15:0], rdata1_n[31:16]};
      default: merged = {rdata2_n[23:0], rdata1_n[31:24]};
    endcase
    case (size_q)
      2'b00:   extended = {{24{~uns_q & merged[7]}},  merged[7:0]};
      2'b01:   extended = {{16{~uns_q & merged[15]}}, merged[15:0]};
      default: extended = merged;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = in_illegal ? ERR : REQ1;
      REQ1:  if (mem_gnt_i) state_d = we_q ? (spans ? REQ2 : DONE) : WAIT1;
      WAIT1: if (mem_rvalid_i) state_d = spans ? REQ2 : DONE;
      REQ2:  if (mem_gnt_i) state_d = we_q ? DONE : WAIT2;
      WAIT2: if (mem_rvalid_i) state_d = DONE;
      DONE:  state_d = IDLE;
      ERR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lsu_ready_o = 1'b0;
    lsu_done_o  = 1'b0;
    lsu_err_o   = 1'b0;
    mem_req_o   = 1'b0;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'b0000;
    mem_wdata_o = '0;
    case (state_q)
      IDLE: lsu_ready_o = 1'b1;
      REQ1: begin
        mem_req_o   = 1'b1;
        mem_addr_o  = word_addr;
        mem_we_o    = we_q;
        mem_be_o    = mask64[3:0];
        mem_wdata_o = wd64[XLEN-1:0];
      end
      REQ2: begin
        mem_req_o   = 1'b1;
        mem_addr_o  = word_addr + 32'd4;
        mem_we_o    = we_q;
        mem_be_o    = mask64[7:4];
        mem_wdata_o = wd64[2*XLEN-1:XLEN];
      end
      DONE: lsu_done_o = 1'b1;
      ERR:  lsu_err_o  = 1'b1;
      default: ;
    endcase
  end

  assign lsu_rdata_o = rdata_q;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q   <= '0;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      uns_q    <= 1'b0;
      wdata_q  <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      rdata_q  <= '0;
    end else begin
      if (accept) begin
        addr_q   <= lsu_addr_i;
        we_q     <= lsu_we_i;
        size_q   <= lsu_size_i;
        uns_q    <= lsu_unsigned_i;
        wdata_q  <= lsu_wdata_i;
        rdata1_q <= '0;
        rdata2_q <= '0;
      end else begin
        rdata1_q <= rdata1_n;
        rdata2_q <= rdata2_n;
      end
      // Result lives only for the DONE cycle of a load; zero otherwise
      rdata_q <= (state_d == DONE && !we_q) ? extended : '0;
    end
  end

  // Read data while a request is still outstanding is a bus protocol violation
  rvalid_during_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(mem_rvalid_i && mem_req_o));

endmodule

// File: tb/tb_lsu_access_sequencer.sv
// Directed and randomized load/store accesses against a byte-lane reference model,
// with bus beats and results tracked in expected queues.
module tb_lsu_access_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lsu_valid, lsu_we, lsu_unsigned;
  logic [1:0]  lsu_size;
  logic [31:0] lsu_addr, lsu_wdata;
  logic        lsu_ready, lsu_done, lsu_err;
  logic [31:0] lsu_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  dbg_state;

  logic        lsu_valid_nm;
  logic        nm_ready, nm_done, nm_err, nm_req, nm_we;
  logic [31:0] nm_rdata, nm_addr, nm_wdata;
  logic [3:0]  nm_be;
  logic [2:0]  nm_state;
  logic        nm_gnt, nm_rvalid;
  logic [31:0] nm_mem_rdata;

  int checks = 0;
  int errors = 0;
  int extra_beats;

  logic [68:0] exp_beat_q[$];
  logic [32:0] exp_q[$];

  lsu_access_sequencer #(.XLEN(32), .SUPPORT_MISALIGNED(1'b1)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready), .lsu_addr_i(lsu_addr),
    .lsu_we_i(lsu_we), .lsu_size_i(lsu_size), .lsu_unsigned_i(lsu_unsigned),
    .lsu_wdata_i(lsu_wdata), .lsu_done_o(lsu_done), .lsu_err_o(lsu_err),
    .lsu_rdata_o(lsu_rdata), .mem_req_o(mem_req), .mem_addr_o(mem_addr),
    .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .dbg_state_o(dbg_state)
  );

  lsu_access_sequencer #(.XLEN(32), .SUPPORT_MISALIGNED(1'b0)) u_dut_nm (
    .clk_i(clk), .rst_ni(rst_n),
    .lsu_valid_i(lsu_valid_nm), .lsu_ready_o(nm_ready), .lsu_addr_i(lsu_addr),
    .lsu_we_i(lsu_we), .lsu_size_i(lsu_size), .lsu_unsigned_i(lsu_unsigned),
    .lsu_wdata_i(lsu_wdata), .lsu_done_o(nm_done), .lsu_err_o(nm_err),
    .lsu_rdata_o(nm_rdata), .mem_req_o(nm_req), .mem_addr_o(nm_addr),
    .mem_we_o(nm_we), .mem_be_o(nm_be), .mem_wdata_o(nm_wdata),
    .mem_gnt_i(nm_gnt), .mem_rvalid_i(nm_rvalid), .mem_rdata_i(nm_mem_rdata),
    .dbg_state_o(nm_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [68:0] obs, input logic [68:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Byte-lane reference model: places each store byte / gathers each load byte individually
  function automatic void model(input logic [31:0] addr, input logic [1:0] size,
                                input logic uns, input logic we, input logic [31:0] wdata,
                                input logic [31:0] w1, input logic [31:0] w2, input bit sup_mis,
                                output logic err, output int nbeats,
                                output logic [68:0] b1, output logic [68:0] b2,
                                output logic [31:0] res);
    int nb, off, pos;
    logic [63:0] wl;
    logic [7:0]  bel;
    logic [31:0] a1, r;
    logic        mis;
    off = int'(addr[1:0]);
    nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    mis = (off % nb) != 0;
    err = (size == 2'd3) || (!sup_mis && mis);
    nbeats = 0; b1 = '0; b2 = '0; res = '0;
    if (err) return;
    wl = '0; bel = '0;
    for (int i = 0; i < 4; i++) begin
      pos = off + i;
      wl[8*pos +: 8] = wdata[8*i +: 8];
      if (i < nb) bel[pos] = 1'b1;
    end
    a1 = addr & ~32'h3;
    b1 = {we, bel[3:0], a1, wl[31:0]};
    b2 = {we, bel[7:4], a1 + 32'd4, wl[63:32]};
    nbeats = (bel[7:4] != 4'b0) ? 2 : 1;
    r = '0;
    for (int i = 0; i < nb; i++) begin
      pos = off + i;
      if (pos < 4) r[8*i +: 8] = w1[8*pos +: 8];
      else         r[8*i +: 8] = w2[8*(pos-4) +: 8];
    end
    if (!uns && r[8*nb-1])
      for (int i = nb; i < 4; i++) r[8*i +: 8] = 8'hFF;
    res = we ? 32'h0 : r;
  endfunction

  // Driver: issue one access, act as the memory, check beats, result and latency
  task automatic run_access(input string tag, input logic [31:0] addr, input logic we,
                            input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                            input logic [31:0] w1, input logic [31:0] w2, input int gnt_wait);
    logic        err;
    int          nbeats, cyc, granted, returned, hold, exp_lat;
    logic [68:0] b1, b2, cur;
    logic [31:0] res;
    logic [32:0] e;
    bit          have, finished;
    model(addr, size, uns, we, wdata, w1, w2, 1'b1, err, nbeats, b1, b2, res);
    if (nbeats >= 1) exp_beat_q.push_back(b1);
    if (nbeats == 2) exp_beat_q.push_back(b2);
    exp_q.push_back({err, res});
    exp_lat = err ? 1 : (we ? nbeats + 1 : 2 * nbeats + 1) + gnt_wait;
    extra_beats = 0;
    @(negedge clk);
    check({tag, "_ready_idle"}, lsu_ready, 1);
    lsu_valid = 1'b1; lsu_addr = addr; lsu_we = we; lsu_size = size;
    lsu_unsigned = uns; lsu_wdata = wdata;
    @(negedge clk);
    lsu_valid = 1'b0;
    cyc = 1; granted = 0; returned = 0; have = 0; hold = gnt_wait; finished = 0; cur = '0;
    while (!finished && cyc < 40) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom();
      if (lsu_done || lsu_err) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h0;
        check({tag, "_result"}, {lsu_err, lsu_rdata}, e);
        check({tag, "_latency"}, cyc, exp_lat);
        finished = 1;
      end else begin
        check({tag, "_ready_busy"}, lsu_ready, 0);
        if (mem_req) begin
          if (!have) begin
            if (exp_beat_q.size() > 0) cur = exp_beat_q.pop_front();
            else begin extra_beats++; cur = {mem_we, mem_be, mem_addr, mem_wdata}; end
            have = 1;
          end
          check({tag, "_beat"}, {mem_we, mem_be, mem_addr, mem_wdata}, cur);
          if (hold > 0) hold--;
          else begin mem_gnt = 1'b1; have = 0; granted++; end
        end else if (!we && granted > returned) begin
          mem_rvalid = 1'b1;
          mem_rdata  = (returned == 0) ? w1 : w2;
          returned++;
        end
      end
      if (!finished) begin @(negedge clk); cyc++; end
    end
    check({tag, "_completed"}, finished, 1);
    check({tag, "_beats_left"}, exp_beat_q.size(), 0);
    check({tag, "_extra_beats"}, extra_beats, 0);
    exp_beat_q.delete();
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    check({tag, "_pulse_end"}, {lsu_done, lsu_err, lsu_ready}, 3'b001);
  endtask

  // Driver for the no-misaligned-support instance: every access given here must error
  task automatic run_nm(input string tag, input logic [31:0] addr, input logic [1:0] size,
                        input logic we);
    logic        err;
    int          nbeats, cyc, req_seen;
    logic [68:0] b1, b2;
    logic [31:0] res;
    logic [32:0] e;
    bit          finished;
    model(addr, size, 1'b0, we, 32'h0, 32'h0, 32'h0, 1'b0, err, nbeats, b1, b2, res);
    exp_q.push_back({err, res});
    @(negedge clk);
    lsu_valid_nm = 1'b1; lsu_addr = addr; lsu_size = size; lsu_we = we;
    lsu_unsigned = 1'b0; lsu_wdata = 32'h0;
    @(negedge clk);
    lsu_valid_nm = 1'b0;
    cyc = 1; finished = 0; req_seen = 0;
    while (!finished && cyc < 10) begin
      if (nm_req) req_seen++;
      if (nm_done || nm_err) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h0;
        check({tag, "_result"}, {nm_err, nm_rdata}, e);
        check({tag, "_latency"}, cyc, 1);
        finished = 1;
      end else begin
        @(negedge clk); cyc++;
      end
    end
    check({tag, "_completed"}, finished, 1);
    check({tag, "_no_req"}, req_seen, 0);
    @(negedge clk);
    check({tag, "_pulse_end"}, {nm_done, nm_err, nm_ready, nm_req}, 4'b0010);
  endtask

  initial begin
    rst_n = 1'b0;
    lsu_valid = 1'b0; lsu_valid_nm = 1'b0; lsu_addr = '0; lsu_we = 1'b0;
    lsu_size = 2'b00; lsu_unsigned = 1'b0; lsu_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    nm_gnt = 1'b0; nm_rvalid = 1'b0; nm_mem_rdata = '0;
    repeat (2) @(negedge clk);
    check("reset_bus", {mem_req, mem_we, mem_be, mem_addr, mem_wdata}, '0);
    check("reset_lsu", {lsu_done, lsu_err, lsu_rdata, lsu_ready}, 34'h1);
    check("reset_nm", {nm_done, nm_err, nm_req, nm_ready}, 4'b0001);
    rst_n = 1'b1;

    run_access("lw_aligned",   32'h100, 1'b0, 2'b10, 1'b0, 32'h0, 32'h800000FF, 32'h0, 0);
    run_access("lb_0x103",     32'h103, 1'b0, 2'b00, 1'b0, 32'h0, 32'h80AABBCC, 32'h0, 0);
    run_access("lbu_0x103",    32'h103, 1'b0, 2'b00, 1'b1, 32'h0, 32'h80AABBCC, 32'h0, 0);
    run_access("lw_split",     32'h102, 1'b0, 2'b10, 1'b0, 32'h0, 32'h2211AAAA, 32'hBBBB4433, 0);
    run_access("sh_split",     32'h103, 1'b1, 2'b01, 1'b0, 32'h0000BEEF, 32'h0, 32'h0, 0);
    run_access("size_illegal", 32'h100, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 0);
    run_access("lw_gnt_wait",  32'h100, 1'b0, 2'b10, 1'b0, 32'h0, 32'hCAFEF00D, 32'h0, 3);
    run_access("lh_off1",      32'h101, 1'b0, 2'b01, 1'b0, 32'h0, 32'h00F00D00, 32'h0, 0);
    run_access("sw_aligned",   32'h200, 1'b1, 2'b10, 1'b0, 32'hA5A55A5A, 32'h0, 32'h0, 0);
    run_access("lhu_off2",     32'h0FE, 1'b0, 2'b01, 1'b1, 32'h0, 32'h9ABC1234, 32'h0, 0);
    run_access("lw_wrap",      32'hFFFFFFFE, 1'b0, 2'b10, 1'b0, 32'h0, 32'h5678FFFF, 32'hEEEE1234, 1);
    run_access("sb_off1",      32'h001, 1'b1, 2'b00, 1'b0, 32'h12345678, 32'h0, 32'h0, 0);
    run_access("sw_split",     32'h303, 1'b1, 2'b10, 1'b0, 32'hDDCCBBAA, 32'h0, 32'h0, 2);

    for (int i = 0; i < 10; i++) begin
      run_access("rand", $urandom(), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                 1'($urandom_range(0, 1)), $urandom(), $urandom(), $urandom(),
                 $urandom_range(0, 2));
    end

    // Abort a split load in WAIT2, then present its stale read data while idle
    @(negedge clk);
    lsu_valid = 1'b1; lsu_addr = 32'h102; lsu_size = 2'b10; lsu_we = 1'b0; lsu_unsigned = 1'b0;
    @(negedge clk);
    lsu_valid = 1'b0;
    check("abort_b1_addr", mem_addr, 32'h100);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h11223344;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("abort_b2_addr", mem_addr, 32'h104);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_bus", {mem_req, mem_we, mem_be, mem_addr, mem_wdata}, '0);
    check("abort_lsu", {lsu_done, lsu_err, lsu_rdata, lsu_ready}, 34'h1);
    @(negedge clk);
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("stale_rvalid_1", {lsu_done, lsu_err, lsu_ready, mem_req}, 4'b0010);
    @(negedge clk);
    check("stale_rvalid_2", {lsu_done, lsu_err, lsu_rdata, lsu_ready}, 35'h1);
    run_access("lw_after_abort", 32'h300, 1'b0, 2'b10, 1'b0, 32'h0, 32'h13579BDF, 32'h0, 0);

    run_nm("nm_lw_mis",   32'h102, 2'b10, 1'b0);
    run_nm("nm_sh_mis",   32'h101, 2'b01, 1'b1);
    run_nm("nm_lh_off3",  32'h103, 2'b01, 1'b0);
    run_nm("nm_size_ill", 32'h100, 2'b11, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_access_sequencer.md
Name: lsu_access_sequencer

Overview:
Sequences core load/store requests onto the single-port data-memory bus (req/gnt/rvalid, one outstanding transaction). Generates aligned word addresses and byte enables, and lane-shifts store data. Splits misaligned half/word accesses into two aligned beats and merges them. Sign- or zero-extends load results before returning them to the writeback stage. Sits between the execute stage and the data-memory port.

Parameters:
XLEN, 32, data width; only 32 is supported.
SUPPORT_MISALIGNED, 1, 1 = split misaligned accesses into two beats; 0 = flag them as errors with no bus access.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
lsu_valid_i  in  1  core request valid
lsu_ready_o  out  1  sequencer can accept a request
lsu_addr_i  in  XLEN  byte address
lsu_we_i  in  1  1 = store, 0 = load
lsu_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
lsu_unsigned_i  in  1  1 = zero-extend load, 0 = sign-extend
lsu_wdata_i  in  XLEN  store data, right-aligned
lsu_done_o  out  1  one-cycle completion pulse
lsu_err_o  out  1  one-cycle error pulse, in place of done
lsu_rdata_o  out  XLEN  extended load data, valid with done
mem_req_o  out  1  bus request
mem_addr_o  out  XLEN  word-aligned address, bits [1:0] = 0
mem_we_o  out  1  bus write
mem_be_o  out  4  byte enables
mem_wdata_o  out  XLEN  lane-shifted write data
mem_gnt_i  in  1  bus accepted request this cycle
mem_rvalid_i  in  1  read data valid
mem_rdata_i  in  XLEN  read data

Behaviour:
- Reset (async, rst_ni=0): FSM goes to IDLE. All outputs are 0 except lsu_ready_o, which is 1. Internal registers are cleared. This applies in any state, including mid-transaction; a later rvalid belonging to the aborted transaction is ignored while in IDLE.
- FSM states: IDLE, REQ1, WAIT1, REQ2, WAIT2, DONE, ERR.
- IDLE: lsu_ready_o=1. On valid & ready, register addr, we, size, unsigned and wdata.
  - If size = 11, or the access is misaligned and SUPPORT_MISALIGNED=0, go to ERR.
  - Otherwise go to REQ1.
- Offset and span: off = addr[1:0]; nbytes = 1, 2 or 4. The access spans two words when off + nbytes > 4.
- Lane maps:
  - mask64 = {4'b0, m} << off, where m = 0001, 0011 or 1111.
  - wd64 = {32'b0, wdata} << (8*off).
  - Beat 1 uses the low halves; beat 2 uses the high halves.
- REQ1: mem_req_o=1, mem_addr_o = {addr[31:2], 2'b00}, mem_be_o = mask64[3:0], mem_wdata_o = wd64[31:0], mem_we_o = we.
  - Request and address fields are held stable until mem_gnt_i.
  - On gnt, a store goes to REQ2 if it spans two words, else DONE. A load goes to WAIT1.
- WAIT1: mem_req_o=0. On rvalid, capture rdata1, then go to REQ2 if spanning, else DONE.
- REQ2: same as REQ1 but with address +4 (32-bit wrap-around; 0xFFFFFFFE+... wraps to 0x00000000), mask64[7:4] and wd64[63:32]. On gnt, a store goes to DONE and a load goes to WAIT2.
- WAIT2: on rvalid, capture rdata2 and go to DONE.
- Load merge: r = ({rdata2, rdata1} >> (8*off))[31:0], then extend.
  - Byte: bits [7:0]. Half: bits [15:0]. Word: all 32 bits.
  - Sign-extend when unsigned=0, zero-extend when unsigned=1.
  - For a store, lsu_rdata_o = 0.
- DONE: lsu_done_o=1 for exactly one cycle; lsu_rdata_o is registered and stable during that cycle. Next state is IDLE.
- ERR: lsu_err_o=1 for one cycle with no bus activity; lsu_rdata_o = 0. Next state is IDLE.
- Latency: a request is accepted in cycle 0 and mem_req_o rises in cycle 1. With zero-wait gnt and rvalid one cycle after gnt:
  - aligned load: done in cycle 3
  - aligned store: done in cycle 2
  - split load: done in cycle 5
- lsu_ready_o is 0 in every state except IDLE; no new request is accepted until the FSM has passed through DONE or ERR.
- rvalid seen in REQ states is ignored (protocol violation; assertion). gnt and rvalid in the same cycle are never both used for the same beat.

Test Plan:
- Aligned lw at 0x100, mem_rdata=0x800000FF -> one beat with be=1111, addr=0x100; lsu_rdata_o=0x800000FF with done in cycle 3.
- lb / lbu at 0x103, mem_rdata=0x80AABBCC -> be=1000; lb returns 0xFFFFFF80, lbu returns 0x00000080.
- Misaligned lw at 0x102; beat 1 at 0x100 reads 0x2211AAAA, beat 2 at 0x104 reads 0xBBBB4433 -> be=1100 then 0011; lsu_rdata_o=0x44332211.
- Misaligned sh at 0x103, wdata=0x0000BEEF:
  - beat 1: addr 0x100, be=1000, wdata byte3=0xEF
  - beat 2: addr 0x104, be=0001, wdata byte0=0xBE
  - done follows beat 2's gnt.
- Size=11, or misaligned lw with SUPPORT_MISALIGNED=0 -> lsu_err_o pulses one cycle, mem_req_o never rises, ready returns the next cycle.
- rst_ni low during WAIT2, then a stale rvalid after release -> all outputs 0 and ready=1; no done pulse; the next aligned lw completes normally. gnt is held off for 3 cycles on a normal lw -> addr and be stay stable.
